dsram_axi_bridge: RTL
=====================

// Module: dsram_axi_bridge
// PURPOSE
// Responder for the CPU data-side sram-like port (en/wen/addr/wdata -> rdata/d_stall).
// Converts each CPU access into one single-beat AXI3/4 transaction (read or write).
// Sits between the CPU top and the AXI interconnect on the uncached (no_dcache) path.
// Holds data_sram_d_stall high until the access completes, then releases it for the CPU.
// PARAMETERS
// WAIT_B    1      1: write completes on B handshake; 0: completes once AW and W have both handshaken
// ERR_DATA  32'h0  value returned on data_sram_rdata when RRESP != OKAY
// PORTS
// clk               in   1   clock
// rst               in   1   synchronous reset, active-high
// data_sram_en      in   1   access request, held stable by CPU while stalled
// data_sram_wen     in   4   byte write enables; 4'b0000 = read
// data_sram_addr    in   32  physical byte address (already unmapped by CPU)
// data_sram_wdata   in   32  write data, byte lanes per wen
// data_sram_rdata   out  32  read data, valid in DONE
// data_sram_d_stall out  1   stall to CPU (combinational)
// ext_stall         in   1   CPU held by another source (instruction side)
// araddr            out  32  AXI read address
// arvalid           out  1   AXI read address valid
// arready           in   1   AXI read address ready
// rdata             in   32  AXI read data
// rresp             in   2   AXI read response
// rvalid            in   1   AXI read data valid
// rready            out  1   AXI read data ready
// awaddr            out  32  AXI write address
// awvalid           out  1   AXI write address valid
// awready           in   1   AXI write address ready
// wdata             out  32  AXI write data
// wstrb             out  4   AXI write strobes (= captured wen)
// wvalid            out  1   AXI write data valid (WLAST tied 1 at top)
// wready            in   1   AXI write data ready
// bresp             in   2   AXI write response (ignored beyond capture)
// bvalid            in   1   AXI write response valid
// bready            out  1   AXI write response ready
// IDs, LEN=0, SIZE=2, BURST, LOCK, CACHE, PROT are constants tied at the top level.
// BEHAVIOUR
// - Reset: state IDLE; all valid/ready outputs 0; data_sram_rdata 0; addr/wdata/wstrb regs 0.
// - States: IDLE, RD_A, RD_D, WR, WR_B, DONE.
// - data_sram_d_stall = data_sram_en & (state != DONE).
// - IDLE & en: capture addr/wdata/wen; wen==0 -> RD_A (arvalid=1) else WR (awvalid=wvalid=1).
// - RD_A: hold arvalid/araddr until arready; then RD_D with rready=1.
// - RD_D: on rvalid: rdata (or ERR_DATA if rresp!=0) -> data_sram_rdata; rready=0; -> DONE.
// - WR: AW and W tracked independently; each valid drops on its own handshake (same-cycle ok).
//   Both done: WAIT_B=1 -> WR_B (bready=1); WAIT_B=0 -> DONE (bready held 1, B drained in IDLE).
// - WR_B: on bvalid -> bready=0, DONE.
// - DONE: stall low; rdata stable; stay while ext_stall=1; leave to IDLE when ext_stall=0.
//   Minimum latency: request cycle 0, AXI same-cycle ready/valid -> DONE at cycle 3 (read).
// - en low at any point mid-transaction: AXI transaction still completes (no valid dropped),
//   passes through DONE, result discarded by CPU.
// - Back-to-back: new request accepted in IDLE the cycle after DONE; no re-issue of old access.
// - WAIT_B=0: a new write is not started until the previous B is accepted (max 1 outstanding).
// - rst mid-transaction: immediate IDLE, all valids low; interconnect is reset in the same cycle.
// TESTING
// - Read, arready/rvalid immediate, rdata=32'hDEADBEEF -> d_stall high 3 cycles, DONE rdata=DEADBEEF.
// - Write wen=4'b0011 addr=0x1FC0_0004, wready 2 cycles before awready -> wstrb=3, 1 AW/W each, B then DONE.
// - ext_stall=1 for 4 cycles at DONE -> no second arvalid; rdata held; IDLE after ext_stall drops.
// - rresp=2'b10 -> data_sram_rdata=ERR_DATA, no hang.
// - rst asserted in RD_D -> next cycle IDLE, arvalid=rready=0, rdata=0, d_stall=en.
// - 100 random back-to-back R/W with random ready delays -> each access exactly 1 AXI txn, data matches model.

Source files
------------

// File: rtl/dsram_axi_bridge.sv
// Data-side sram-like port to single-beat AXI read/write bridge.
// Ports: clk/rst, CPU sram port (en/wen/addr/wdata/rdata/d_stall, ext_stall), AXI AR/R/AW/W/B.
module dsram_axi_bridge #(
  parameter bit          WAIT_B   = 1'b1,
  parameter logic [31:0] ERR_DATA = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_d_stall,
  input  logic        ext_stall,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE, RD_A, RD_D, WR, WR_B, DONE
  } state_t;

  state_t      state, state_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] wdata_n, rdata_n;
  logic [3:0]  wstrb_n;
  logic        arvalid_n, rready_n;
  logic        awvalid_n, wvalid_n, bready_n;
  logic        aw_left, w_left;
  logic        unused_bresp;

  assign unused_bresp = ^bresp;
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign data_sram_d_stall = data_sram_en & (state != DONE);

  assign aw_left = awvalid & ~awready;
  assign w_left  = wvalid & ~wready;

  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    wdata_n   = wdata;
    wstrb_n   = wstrb;
    rdata_n   = data_sram_rdata;
    arvalid_n = arvalid;
    rready_n  = rready;
    awvalid_n = awvalid;
    wvalid_n  = wvalid;
    bready_n  = bready;
    // Without WAIT_B the response is drained in the background
    if (!WAIT_B && bready && bvalid)
      bready_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (data_sram_en) begin
          addr_n  = data_sram_addr;
          wdata_n = data_sram_wdata;
          wstrb_n = data_sram_wen;
          if (data_sram_wen == 4'b0000) begin
            arvalid_n = 1'b1;
            state_n   = RD_A;
          end else if (!bready) begin
            // Only one write response may be outstanding
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = WR;
          end
        end
      end
      RD_A: begin
        if (arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_D;
        end
      end
      RD_D: begin
        if (rvalid) begin
          rdata_n  = (rresp != 2'b00) ? ERR_DATA : rdata;
          rready_n = 1'b0;
          state_n  = DONE;
        end
      end
      WR: begin
        awvalid_n = aw_left;
        wvalid_n  = w_left;
        if (!aw_left && !w_left) begin
          bready_n = 1'b1;
          state_n  = WAIT_B ? WR_B : DONE;
        end
      end
      WR_B: begin
        if (bvalid) begin
          bready_n = 1'b0;
          state_n  = DONE;
        end
      end
      DONE: begin
        if (!ext_stall)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      addr_q          <= 32'h0;
      wdata           <= 32'h0;
      wstrb           <= 4'h0;
      data_sram_rdata <= 32'h0;
      arvalid         <= 1'b0;
      rready          <= 1'b0;
      awvalid         <= 1'b0;
      wvalid          <= 1'b0;
      bready          <= 1'b0;
    end else begin
      state           <= state_n;
      addr_q          <= addr_n;
      wdata           <= wdata_n;
      wstrb           <= wstrb_n;
      data_sram_rdata <= rdata_n;
      arvalid         <= arvalid_n;
      rready          <= rready_n;
      awvalid         <= awvalid_n;
      wvalid          <= wvalid_n;
      bready          <= bready_n;
    end
  end

endmodule
